// File: rtl/wb_arbiter2.sv
// Two-master Wishbone arbiter: round-robin whole-cycle grants onto one slave port,
// with a slave-response watchdog that terminates hung cycles with an error.
module wb_arbiter2 #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    input  logic        m0_we_i,
    input  logic [31:0] m0_adr_i,
    input  logic [31:0] m0_dat_i,
    input  logic [3:0]  m0_sel_i,
    output logic [31:0] m0_dat_o,
    output logic        m0_ack_o,
    output logic        m0_err_o,
    output logic        m0_rty_o,

    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    input  logic        m1_we_i,
    input  logic [31:0] m1_adr_i,
    input  logic [31:0] m1_dat_i,
    input  logic [3:0]  m1_sel_i,
    output logic [31:0] m1_dat_o,
    output logic        m1_ack_o,
    output logic        m1_err_o,
    output logic        m1_rty_o,

    output logic        s_cyc_o,
    output logic        s_stb_o,
    output logic        s_we_o,
    output logic [31:0] s_adr_o,
    output logic [31:0] s_dat_o,
    output logic [3:0]  s_sel_o,
    input  logic [31:0] s_dat_i,
    input  logic        s_ack_i,
    input  logic        s_err_i,
    input  logic        s_rty_i,

    output logic [1:0]  grant_o,
    output logic        timeout_o
);

    // State encoding doubles as the one-hot grant vector.
    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] GNT0 = 2'b01;
    localparam logic [1:0] GNT1 = 2'b10;

    localparam logic        WD_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [15:0] WD_LAST = 16'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    logic [1:0]  state, state_nxt;
    logic        last, last_nxt;
    logic [15:0] wd, wd_nxt;

    logic        g_cyc, g_stb, g_we;
    logic [31:0] g_adr, g_dat;
    logic [3:0]  g_sel;
    logic        granted, s_term, expire;

    always_comb begin
        g_cyc = 1'b0;
        g_stb = 1'b0;
        g_we  = 1'b0;
        g_adr = '0;
        g_dat = '0;
        g_sel = '0;
        case (state)
            GNT0: begin
                g_cyc = m0_cyc_i;
                g_stb = m0_stb_i;
                g_we  = m0_we_i;
                g_adr = m0_adr_i;
                g_dat = m0_dat_i;
                g_sel = m0_sel_i;
            end
            GNT1: begin
                g_cyc = m1_cyc_i;
                g_stb = m1_stb_i;
                g_we  = m1_we_i;
                g_adr = m1_adr_i;
                g_dat = m1_dat_i;
                g_sel = m1_sel_i;
            end
            default: ;
        endcase
    end

    assign granted = (state == GNT0) || (state == GNT1);
    assign s_term  = s_ack_i | s_err_i | s_rty_i;
    // A slave termination in the expiry cycle takes priority over the watchdog.
    assign expire  = WD_EN && granted && g_stb && !s_term && (wd == WD_LAST) && !rst_i;

    always_comb begin
        s_cyc_o   = g_cyc & ~rst_i;
        s_stb_o   = g_stb & ~rst_i & ~expire;
        s_we_o    = g_we;
        s_adr_o   = g_adr;
        s_dat_o   = g_dat;
        s_sel_o   = g_sel;
        timeout_o = expire;
        m0_dat_o  = s_dat_i;
        m1_dat_o  = s_dat_i;
        m0_ack_o  = 1'b0;
        m0_err_o  = 1'b0;
        m0_rty_o  = 1'b0;
        m1_ack_o  = 1'b0;
        m1_err_o  = 1'b0;
        m1_rty_o  = 1'b0;
        if (!rst_i) begin
            if (state == GNT0) begin
                m0_ack_o = s_ack_i & ~expire;
                m0_err_o = s_err_i | expire;
                m0_rty_o = s_rty_i & ~expire;
            end
            if (state == GNT1) begin
                m1_ack_o = s_ack_i & ~expire;
                m1_err_o = s_err_i | expire;
                m1_rty_o = s_rty_i & ~expire;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        case (state)
            IDLE: begin
                if (m0_cyc_i && (!m1_cyc_i || last)) begin
                    state_nxt = GNT0;
                    last_nxt  = 1'b0;
                end else if (m1_cyc_i) begin
                    state_nxt = GNT1;
                    last_nxt  = 1'b1;
                end
            end
            GNT0:    if (!m0_cyc_i) state_nxt = IDLE;
            GNT1:    if (!m1_cyc_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        if (!WD_EN || !granted || !g_stb || s_term || expire)
            wd_nxt = '0;
        else
            wd_nxt = wd + 16'd1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            last  <= 1'b1;
            wd    <= '0;
        end else begin
            state <= state_nxt;
            last  <= last_nxt;
            wd    <= wd_nxt;
        end
    end

    assign grant_o = state;

endmodule
